// File: rtl/aer_event_packer.sv
// aer_event_packer
//
// Takes the granted pixel from the row/column round-robin arbiters and adds a
// timestamp from a free-running counter. It packs the result into an
// address-event word and buffers the words in a show-ahead FIFO. When the
// timestamp counter wraps, the block queues a single wrap-marker word. If a
// second wrap arrives while a marker is still waiting, the sticky
// ovf_lost_o flag is raised.
//
// Word layout (MSB first): type | pol | y | x | ts
//   type=0 : event word
//   type=1 : wrap marker, every other field zero
//
// Handshakes (both ports): a transfer happens on a rising clk edge when
// valid and ready are both high. The producer holds its word and valid
// until the transfer happens, and ready never depends on the transfer itself.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   enable_i        : readout enable (timestamp run + event acceptance)
//   evt_valid_i     : arbiter pair presents a granted event
//   evt_ready_o     : event accepted this cycle (enable_i and FIFO not full)
//   y_add_i/x_add_i : granted row / column address
//   pol_i           : event polarity, 1 = ON
//   out_valid_o     : FIFO head word valid
//   out_ready_i     : downstream consumes the head word
//   out_data_o      : FIFO head word
//   level_o         : FIFO occupancy
//   ovf_lost_o      : sticky, a wrap marker was lost
module aer_event_packer #(
    parameter int ROW_AW = 2,
    parameter int COL_AW = 2,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8,
    localparam int DW    = 2 + ROW_AW + COL_AW + TS_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              evt_valid_i,
    output logic              evt_ready_o,
    input  logic [ROW_AW-1:0] y_add_i,
    input  logic [COL_AW-1:0] x_add_i,
    input  logic              pol_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DW-1:0]     out_data_o,
    output logic [LW-1:0]     level_o,
    output logic              ovf_lost_o
);

    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] ts_q;
    logic            wrap_pend;
    logic            ovf_lost_q;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    logic            full;
    logic            push_evt;
    logic            push_mark;
    logic            push;
    logic            pop;
    logic            wrap_edge;
    logic [DW-1:0]   push_word;

    assign full = (level == LW'(DEPTH));

    // Held low during reset so the arbiters never see a grant accepted
    // while the FIFO is being cleared.
    assign evt_ready_o = enable_i & ~full & ~reset;

    assign push_evt  = evt_valid_i & evt_ready_o;
    // An event push takes the single write port ahead of a waiting marker.
    assign push_mark = wrap_pend & ~push_evt & ~full;
    assign push      = push_evt | push_mark;
    assign pop       = out_valid_o & out_ready_i;
    assign wrap_edge = enable_i & (ts_q == '1);

    assign push_word = push_evt ? {1'b0, pol_i, y_add_i, x_add_i, ts_q}
                                : {1'b1, {(DW-1){1'b0}}};

    // Timestamp counter and wrap-marker bookkeeping.
    // A wrap that lands on the same edge as a marker push re-arms wrap_pend
    // for the new wrap, and no marker is lost. A wrap while a marker is still
    // waiting loses that marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            wrap_pend  <= 1'b0;
            ovf_lost_q <= 1'b0;
        end else begin
            if (enable_i) begin
                ts_q <= ts_q + 1'b1;
            end
            if (wrap_edge) begin
                wrap_pend <= 1'b1;
                if (wrap_pend && !push_mark) begin
                    ovf_lost_q <= 1'b1;
                end
            end else if (push_mark) begin
                wrap_pend <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally at AW bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; level gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Show-ahead read: the head entry stays stable until it is popped.
    assign out_data_o  = mem[rd_ptr];
    assign out_valid_o = (level != '0);
    assign level_o     = level;
    assign ovf_lost_o  = ovf_lost_q;

endmodule

// File: tb/tb_aer_event_packer.sv
// Bench for aer_event_packer with a short timestamp and a small FIFO, so that
// wraps, markers, full conditions and lost markers all occur often.
module tb_aer_event_packer;

  localparam int ROW_AW = 2;
  localparam int COL_AW = 2;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 4;
  localparam int DW     = 2 + ROW_AW + COL_AW + TS_W;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int TS_MAX = (1 << TS_W) - 1;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable_i = 1'b0;
  logic              evt_valid_i = 1'b0;
  logic              evt_ready_o;
  logic [ROW_AW-1:0] y_add_i = '0;
  logic [COL_AW-1:0] x_add_i = '0;
  logic              pol_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [DW-1:0]     out_data_o;
  logic [LW-1:0]     level_o;
  logic              ovf_lost_o;

  always #5 clk = ~clk;

  aer_event_packer #(
    .ROW_AW(ROW_AW),
    .COL_AW(COL_AW),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable_i),
    .evt_valid_i(evt_valid_i),
    .evt_ready_o(evt_ready_o),
    .y_add_i    (y_add_i),
    .x_add_i    (x_add_i),
    .pol_i      (pol_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .level_o    (level_o),
    .ovf_lost_o (ovf_lost_o)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            m_ts;
  bit            m_pend;
  bit            m_ovf;
  bit            last_acc;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ev_word(input bit p, input logic [1:0] y,
                                            input logic [1:0] x, input int ts);
    logic [TS_W-1:0] t;
    t = TS_W'(ts);
    return {1'b0, p, y, x, t};
  endfunction

  function automatic logic [DW-1:0] marker_word();
    logic [DW-1:0] w;
    w = '0;
    w[DW-1] = 1'b1;
    return w;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive the inputs after the falling edge, compare the
  // outputs with the model, then advance the model across the next rising edge.
  task automatic step(input bit en, input bit ev, input logic [1:0] y,
                      input logic [1:0] x, input bit p, input bit rdy);
    bit exp_rdy;
    bit mark;
    bit pend_before;
    int sz;
    @(negedge clk);
    enable_i = en; evt_valid_i = ev; y_add_i = y; x_add_i = x;
    pol_i = p; out_ready_i = rdy;
    #1;
    sz = exp_q.size();
    exp_rdy = en && (sz < DEPTH);
    check("evt_ready", evt_ready_o, exp_rdy);
    check("out_valid", out_valid_o, sz != 0);
    check("level", level_o, sz);
    check("ovf_lost", ovf_lost_o, m_ovf);
    if (sz != 0) check("out_data", out_data_o, exp_q[0]);
    last_acc = ev && exp_rdy;
    mark = m_pend && !last_acc && (sz < DEPTH);
    pend_before = m_pend;
    if (rdy && sz != 0) void'(exp_q.pop_front());
    if (last_acc) exp_q.push_back(ev_word(p, y, x, m_ts));
    else if (mark) exp_q.push_back(marker_word());
    if (mark) m_pend = 0;
    if (en) begin
      if (m_ts == TS_MAX) begin
        if (pend_before && !mark) m_ovf = 1;
        m_pend = 1;
      end
      m_ts = (m_ts + 1) % (TS_MAX + 1);
    end
  endtask

  task automatic idle(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) step(en, 1'b0, 2'd0, 2'd0, 1'b0, rdy);
  endtask

  // Assert reset between clock edges, check the immediate effect, and release
  // it with enable low so the release edge does nothing.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    enable_i = 1'b1; evt_valid_i = 1'b1; out_ready_i = 1'b0;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_ready", evt_ready_o, 0);
    check("rst_ovf", ovf_lost_o, 0);
    exp_q.delete();
    m_ts = 0; m_pend = 0; m_ovf = 0;
    repeat (2) @(negedge clk);
    enable_i = 1'b0; evt_valid_i = 1'b0;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit            v;
    bit            p;
    logic [1:0]    y;
    logic [1:0]    x;
    int            rdy_pct;
    int            en_pct;

    do_reset();

    // Single event with the timestamp at 5.
    idle(5, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    check("single_word", out_data_o, 10'h195);
    step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    check("single_level", level_o, 0);

    // Fill to full while the consumer stalls, then drain.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b1, 2'd1, 2'(i), 1'b0, 1'b0);
    check("full_level", level_o, DEPTH);
    check("full_ready", evt_ready_o, 0);
    idle(10, 1'b1, 1'b1);

    // A wrap with no traffic produces exactly one marker.
    do_reset();
    idle(17, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    check("marker_level", level_o, 1);
    check("marker_word", out_data_o, 10'h200);
    idle(4, 1'b1, 1'b1);

    // Events across the wrap edge delay the marker; nothing is lost.
    do_reset();
    idle(14, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'(i), 2'(3 - i), 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);
    check("collide_ovf", ovf_lost_o, 0);

    // Full FIFO across two wraps loses a marker.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 2'd3, 2'(i), 1'b0, 1'b0);
    idle(40, 1'b1, 1'b0);
    check("lost_ovf", ovf_lost_o, 1);
    idle(8, 1'b0, 1'b1);

    // Reset in the middle of a stream, then an event on the first enabled cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd1, 2'(i), 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 2'd3, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    check("post_rst_word", out_data_o, 10'h0e0);

    // Randomized traffic; a refused grant is held until it is accepted.
    do_reset();
    v = 0; p = 0; y = '0; x = '0;
    last_acc = 1'b1;
    rdy_pct = 50; en_pct = 90;
    for (int n = 0; n < 1200; n++) begin
      if (n % 100 == 0) begin
        rdy_pct = $urandom_range(0, 2) * 40 + 10;
        en_pct  = ($urandom_range(0, 3) == 0) ? 50 : 95;
      end
      if (!(v && !last_acc)) begin
        v = ($urandom_range(0, 99) < 60);
        p = 1'($urandom);
        y = 2'($urandom);
        x = 2'($urandom);
      end
      step($urandom_range(0, 99) < en_pct, v, y, x, p,
           $urandom_range(0, 99) < rdy_pct);
      if (n == 600) do_reset();
    end
    idle(12, 1'b0, 1'b1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aer_event_packer.md
Name: aer_event_packer

Overview:
- Sits directly downstream of the row (y) and column (x) round-robin arbiters in the event-based readout chain.
- Each cycle the arbiter pair presents a granted pixel (row address, column address, polarity) with a strobe; this block stamps it with a free-running timestamp.
- It packs the result into an address-event word and buffers words in a FIFO.
- Words drain through a valid/ready output port. FIFO fill status back-pressures the arbiters.

Parameters:
- ROW_AW, 2, row address width (matches the 4-row y arbiter).
- COL_AW, 2, column address width.
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- Derived, not overridable: DW = 2 + ROW_AW + COL_AW + TS_W (22 at defaults).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  readout enable; gates timestamp and event acceptance.
- evt_valid_i  in  1  arbiter pair presents a granted event this cycle.
- evt_ready_o  out  1  event accepted this cycle; high when enable_i=1 and FIFO not full.
- y_add_i  in  ROW_AW  granted row address.
- x_add_i  in  COL_AW  granted column address.
- pol_i  in  1  event polarity (1 = ON).
- out_valid_o  out  1  FIFO head word valid.
- out_ready_i  in  1  downstream consumes head word.
- out_data_o  out  DW  head word.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf_lost_o  out  1  sticky: a timestamp-wrap marker was lost.

Behaviour:
- Word layout, MSB first: [DW-1] type, [DW-2] pol, then y (ROW_AW), then x (COL_AW), then ts (TS_W, LSBs).
  - type=0: event word.
  - type=1: wrap marker; all other fields 0.
- Reset (async): ts_q=0, FIFO empty, wrap_pend=0, ovf_lost_o=0. Outputs: out_valid_o=0, level_o=0, evt_ready_o=0 while reset is asserted.
- Timestamp counter:
  - ts_q increments by 1 on each clk edge with enable_i=1; holds when enable_i=0.
  - Wraps from 2^TS_W-1 to 0.
  - The edge taking ts_q from max to 0 sets wrap_pend=1.
  - If wrap_pend is already 1 at that edge, ovf_lost_o is set and stays 1 until reset.
- Event accept:
  - Push occurs when evt_valid_i & evt_ready_o.
  - Pushed word: type=0, pol_i, y_add_i, x_add_i, ts = ts_q value of the accepting cycle (pre-increment).
  - evt_ready_o is combinational: enable_i & (level != DEPTH).
  - evt_valid_i with evt_ready_o=0 is not accepted. The arbiter must hold its grant; this block never drops an event.
- Marker insertion:
  - Single FIFO write port; an event push has priority.
  - The marker is pushed on the first edge where wrap_pend=1, no event push occurs, and the FIFO is not full. That edge clears wrap_pend.
  - If the wrap and a marker push coincide, wrap_pend stays set and ovf_lost_o is not set.
- FIFO:
  - Show-ahead: out_data_o is the head word whenever out_valid_o=1.
  - out_valid_o = (level != 0).
  - Pop on out_valid_o & out_ready_i.
  - A word pushed at edge N is visible on out_valid_o/out_data_o in the cycle after edge N (1-cycle latency when the FIFO was empty).
  - Simultaneous push and pop: level unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - While full, a pop plus a new evt_valid_i in the same cycle gives no push: evt_ready_o was 0 that cycle, and the push happens next cycle.
  - out_data_o is unconstrained when out_valid_o=0.
  - out_data_o must hold stable while out_valid_o=1 and out_ready_i=0.
- enable_i=0:
  - ts frozen, no event pushes.
  - Pending marker may still be pushed.
  - FIFO continues to drain.
- Reset mid-operation discards all FIFO content and pending markers immediately.

Test Plan:
- Single event, defaults: after reset, enable_i=1 from cycle 0; at ts_q=5 drive evt_valid_i=1 with pol=1, y=2, x=1, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=0x190005; level_o returns to 0 after the pop.
- Backpressure/full, defaults: out_ready_i=0; drive evt_valid_i=1 for 10 cycles with x cycling 0..3 -> exactly 8 pushes; evt_ready_o=0 from the 9th cycle; level_o=8; then out_ready_i=1 -> words drain in order with ascending ts; evt_ready_o=1 again once level_o<8.
- Wrap marker, TS_W=4 (DW=10): enable 16 cycles with no events -> one word 0x200 appears; level_o=1.
- Wrap/event collision, TS_W=4: hold evt_valid_i=1 across the wrap edge for 3 cycles -> marker is delayed until evt_valid_i drops, then pushed as the next word; ovf_lost_o stays 0.
- Lost marker, TS_W=4, DEPTH=2: out_ready_i=0, FIFO filled with 2 events, enable for 32 more cycles -> ovf_lost_o=1 after the second wrap.
- Reset mid-stream: FIFO holding 5 words, assert reset asynchronously between edges -> out_valid_o=0 and level_o=0 immediately; after release, ts restarts at 0 and the first event carries ts=0 when accepted on the first enabled cycle.
